// File: rtl/ycbcr_skin_box.sv
`default_nettype none
// ============================================================================
// Module  : ycbcr_skin_box
// Brief   : Cb/Cr skin-colour mask with per-frame bounding box and pixel count
// Revision: 1.0 - initial release
// ============================================================================

module ycbcr_skin_box #(
   parameter int unsigned CB_MIN  = 77,
   parameter int unsigned CB_MAX  = 127,
   parameter int unsigned CR_MIN  = 133,
   parameter int unsigned CR_MAX  = 173,
   parameter int unsigned COORD_W = 12,
   parameter int unsigned CNT_W   = 20,
   parameter int unsigned MIN_PIX = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync_in,
   input  logic               hsync_in,
   input  logic               de_in,
   input  logic [7:0]         y,
   input  logic [7:0]         cb,
   input  logic [7:0]         cr,
   output logic               vsync_out,
   output logic               hsync_out,
   output logic               de_out,
   output logic [7:0]         bin_out,
   output logic [COORD_W-1:0] box_x_min,
   output logic [COORD_W-1:0] box_x_max,
   output logic [COORD_W-1:0] box_y_min,
   output logic [COORD_W-1:0] box_y_max,
   output logic [CNT_W-1:0]   skin_cnt,
   output logic               box_valid,
   output logic               box_update
);

   localparam logic [7:0]         C_CB_MIN     = CB_MIN[7:0];
   localparam logic [7:0]         C_CB_MAX     = CB_MAX[7:0];
   localparam logic [7:0]         C_CR_MIN     = CR_MIN[7:0];
   localparam logic [7:0]         C_CR_MAX     = CR_MAX[7:0];
   localparam logic [COORD_W-1:0] C_COORD_ALL1 = {COORD_W{1'b1}};
   localparam logic [CNT_W-1:0]   C_CNT_ALL1   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   C_MIN_PIX    = CNT_W'(MIN_PIX);

   localparam logic [0:0] ST_ACCUM   = 1'b0;
   localparam logic [0:0] ST_PUBLISH = 1'b1;

   // Luma is carried alongside the chroma but plays no part in the skin test.
   logic luma_unused;
   assign luma_unused = ^y;

   logic skin;
   logic vs_rise;
   logic de_fall;

   logic               vsync_q, vsync_d;
   logic               hsync_q, hsync_d;
   logic               de_q, de_d;
   logic [7:0]         bin_q, bin_d;
   logic               vs_prev_q, vs_prev_d;
   logic               de_prev_q, de_prev_d;

   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;

   logic [COORD_W-1:0] xmin_acc_q, xmin_acc_d;
   logic [COORD_W-1:0] xmax_acc_q, xmax_acc_d;
   logic [COORD_W-1:0] ymin_acc_q, ymin_acc_d;
   logic [COORD_W-1:0] ymax_acc_q, ymax_acc_d;
   logic [CNT_W-1:0]   cnt_acc_q, cnt_acc_d;

   logic [COORD_W-1:0] snap_xmin_q, snap_xmin_d;
   logic [COORD_W-1:0] snap_xmax_q, snap_xmax_d;
   logic [COORD_W-1:0] snap_ymin_q, snap_ymin_d;
   logic [COORD_W-1:0] snap_ymax_q, snap_ymax_d;
   logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;

   logic [0:0]         state_q, state_d;

   logic [COORD_W-1:0] box_xmin_q, box_xmin_d;
   logic [COORD_W-1:0] box_xmax_q, box_xmax_d;
   logic [COORD_W-1:0] box_ymin_q, box_ymin_d;
   logic [COORD_W-1:0] box_ymax_q, box_ymax_d;
   logic [CNT_W-1:0]   box_cnt_q, box_cnt_d;
   logic               box_valid_q, box_valid_d;
   logic               box_update_q, box_update_d;

   always_comb begin
      skin    = de_in
                && (cb >= C_CB_MIN) && (cb <= C_CB_MAX)
                && (cr >= C_CR_MIN) && (cr <= C_CR_MAX);
      vs_rise = vsync_in & ~vs_prev_q;
      de_fall = ~de_in & de_prev_q;
   end

   // Pixel path and edge-detect history.
   always_comb begin
      vsync_d   = vsync_in;
      hsync_d   = hsync_in;
      de_d      = de_in;
      bin_d     = skin ? 8'hFF : 8'h00;
      vs_prev_d = vsync_in;
      de_prev_d = de_in;
   end

   // Coordinates of the pixel currently on the input are x_q / y_q.
   always_comb begin
      x_d = '0;
      if (de_in) begin
         x_d = (x_q == C_COORD_ALL1) ? x_q : x_q + COORD_W'(1);
      end

      y_d = y_q;
      if (vs_rise) begin
         y_d = '0;
      end else if (de_fall && (y_q != C_COORD_ALL1)) begin
         y_d = y_q + COORD_W'(1);
      end
   end

   // A skin pixel on the vs_rise cycle belongs to neither frame.
   always_comb begin
      xmin_acc_d  = xmin_acc_q;
      xmax_acc_d  = xmax_acc_q;
      ymin_acc_d  = ymin_acc_q;
      ymax_acc_d  = ymax_acc_q;
      cnt_acc_d   = cnt_acc_q;
      snap_xmin_d = snap_xmin_q;
      snap_xmax_d = snap_xmax_q;
      snap_ymin_d = snap_ymin_q;
      snap_ymax_d = snap_ymax_q;
      snap_cnt_d  = snap_cnt_q;

      if (vs_rise) begin
         snap_xmin_d = xmin_acc_q;
         snap_xmax_d = xmax_acc_q;
         snap_ymin_d = ymin_acc_q;
         snap_ymax_d = ymax_acc_q;
         snap_cnt_d  = cnt_acc_q;
         xmin_acc_d  = C_COORD_ALL1;
         xmax_acc_d  = '0;
         ymin_acc_d  = C_COORD_ALL1;
         ymax_acc_d  = '0;
         cnt_acc_d   = '0;
      end else if (skin) begin
         if (x_q < xmin_acc_q) xmin_acc_d = x_q;
         if (x_q > xmax_acc_q) xmax_acc_d = x_q;
         if (y_q < ymin_acc_q) ymin_acc_d = y_q;
         if (y_q > ymax_acc_q) ymax_acc_d = y_q;
         if (cnt_acc_q != C_CNT_ALL1) cnt_acc_d = cnt_acc_q + CNT_W'(1);
      end
   end

   // Publish FSM: the snapshot taken on vs_rise is committed one cycle later.
   always_comb begin
      state_d      = state_q;
      box_xmin_d   = box_xmin_q;
      box_xmax_d   = box_xmax_q;
      box_ymin_d   = box_ymin_q;
      box_ymax_d   = box_ymax_q;
      box_cnt_d    = box_cnt_q;
      box_valid_d  = box_valid_q;
      box_update_d = 1'b0;

      case (state_q)
         ST_ACCUM: begin
            if (vs_rise) state_d = ST_PUBLISH;
         end
         ST_PUBLISH: begin
            if (snap_cnt_q >= C_MIN_PIX) begin
               box_xmin_d  = snap_xmin_q;
               box_xmax_d  = snap_xmax_q;
               box_ymin_d  = snap_ymin_q;
               box_ymax_d  = snap_ymax_q;
               box_valid_d = 1'b1;
            end else begin
               box_xmin_d  = '0;
               box_xmax_d  = '0;
               box_ymin_d  = '0;
               box_ymax_d  = '0;
               box_valid_d = 1'b0;
            end
            box_cnt_d    = snap_cnt_q;
            box_update_d = 1'b1;
            state_d      = vs_rise ? ST_PUBLISH : ST_ACCUM;
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         de_q         <= 1'b0;
         bin_q        <= 8'h00;
         vs_prev_q    <= 1'b0;
         de_prev_q    <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         xmin_acc_q   <= C_COORD_ALL1;
         xmax_acc_q   <= '0;
         ymin_acc_q   <= C_COORD_ALL1;
         ymax_acc_q   <= '0;
         cnt_acc_q    <= '0;
         snap_xmin_q  <= '0;
         snap_xmax_q  <= '0;
         snap_ymin_q  <= '0;
         snap_ymax_q  <= '0;
         snap_cnt_q   <= '0;
         state_q      <= ST_ACCUM;
         box_xmin_q   <= '0;
         box_xmax_q   <= '0;
         box_ymin_q   <= '0;
         box_ymax_q   <= '0;
         box_cnt_q    <= '0;
         box_valid_q  <= 1'b0;
         box_update_q <= 1'b0;
      end else begin
         vsync_q      <= vsync_d;
         hsync_q      <= hsync_d;
         de_q         <= de_d;
         bin_q        <= bin_d;
         vs_prev_q    <= vs_prev_d;
         de_prev_q    <= de_prev_d;
         x_q          <= x_d;
         y_q          <= y_d;
         xmin_acc_q   <= xmin_acc_d;
         xmax_acc_q   <= xmax_acc_d;
         ymin_acc_q   <= ymin_acc_d;
         ymax_acc_q   <= ymax_acc_d;
         cnt_acc_q    <= cnt_acc_d;
         snap_xmin_q  <= snap_xmin_d;
         snap_xmax_q  <= snap_xmax_d;
         snap_ymin_q  <= snap_ymin_d;
         snap_ymax_q  <= snap_ymax_d;
         snap_cnt_q   <= snap_cnt_d;
         state_q      <= state_d;
         box_xmin_q   <= box_xmin_d;
         box_xmax_q   <= box_xmax_d;
         box_ymin_q   <= box_ymin_d;
         box_ymax_q   <= box_ymax_d;
         box_cnt_q    <= box_cnt_d;
         box_valid_q  <= box_valid_d;
         box_update_q <= box_update_d;
      end
   end

   assign vsync_out  = vsync_q;
   assign hsync_out  = hsync_q;
   assign de_out     = de_q;
   assign bin_out    = bin_q;
   assign box_x_min  = box_xmin_q;
   assign box_x_max  = box_xmax_q;
   assign box_y_min  = box_ymin_q;
   assign box_y_max  = box_ymax_q;
   assign skin_cnt   = box_cnt_q;
   assign box_valid  = box_valid_q;
   assign box_update = box_update_q;

endmodule

`default_nettype wire

// File: tb/tb_ycbcr_skin_box.sv
`default_nettype none
// ============================================================================
// Module  : tb_ycbcr_skin_box
// Brief   : Directed self-checking bench for ycbcr_skin_box
// Revision: 1.0 - initial release
// ============================================================================

module tb_ycbcr_skin_box;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vsync_in, hsync_in, de_in;
   logic [7:0]  y, cb, cr;
   logic        vsync_out, hsync_out, de_out;
   logic [7:0]  bin_out;
   logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
   logic [19:0] skin_cnt;
   logic        box_valid, box_update;

   int tests = 0;
   int fails = 0;

   ycbcr_skin_box dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vsync_in   (vsync_in),
      .hsync_in   (hsync_in),
      .de_in      (de_in),
      .y          (y),
      .cb         (cb),
      .cr         (cr),
      .vsync_out  (vsync_out),
      .hsync_out  (hsync_out),
      .de_out     (de_out),
      .bin_out    (bin_out),
      .box_x_min  (box_x_min),
      .box_x_max  (box_x_max),
      .box_y_min  (box_y_min),
      .box_y_max  (box_y_max),
      .skin_cnt   (skin_cnt),
      .box_valid  (box_valid),
      .box_update (box_update)
   );

   always #5 clk = ~clk;

   // Drive one pixel and return 1 time unit after the edge that captured it.
   task automatic px(input logic vs, input logic hs, input logic de,
                     input logic [7:0] c_b, input logic [7:0] c_r);
      vsync_in = vs;
      hsync_in = hs;
      de_in    = de;
      cb       = c_b;
      cr       = c_r;
      y        = 8'h80;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int w, input int h, input int x0, input int x1,
                             input int y0, input int y1);
      for (int l = 0; l < h; l++) begin
         px(0, 1, 0, 8'd0, 8'd0);
         px(0, 1, 0, 8'd0, 8'd0);
         px(0, 0, 0, 8'd0, 8'd0);
         px(0, 0, 0, 8'd0, 8'd0);
         for (int c = 0; c < w; c++) begin
            if (c >= x0 && c <= x1 && l >= y0 && l <= y1) px(0, 0, 1, 8'd100, 8'd150);
            else                                          px(0, 0, 1, 8'd50, 8'd50);
         end
      end
      repeat (4) px(0, 0, 0, 8'd0, 8'd0);
   endtask

   // vs_rise cycle, then the publish cycle; caller checks the published values.
   task automatic frame_edge();
      px(1, 0, 0, 8'd0, 8'd0);
      px(1, 0, 0, 8'd0, 8'd0);
   endtask

   task automatic test_reset();
      vsync_in = 1; hsync_in = 1; de_in = 1; cb = 8'd100; cr = 8'd150; y = 8'h80;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({vsync_out, hsync_out, de_out, bin_out, box_x_min, box_x_max, box_y_min,
           box_y_max, skin_cnt, box_valid, box_update} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %h required 0",
                  {vsync_out, hsync_out, de_out, bin_out, box_x_min, box_x_max,
                   box_y_min, box_y_max, skin_cnt, box_valid, box_update});
      end
      vsync_in = 0; hsync_in = 0; de_in = 0;
      rst_n = 1'b1;
      px(0, 1, 1, 8'd100, 8'd150);
      tests++;
      if ({vsync_out, hsync_out, de_out, bin_out} !== {1'b0, 1'b1, 1'b1, 8'hFF}) begin
         fails++;
         $display("FAIL reset_first_pixel: vs/hs/de/bin=%b%b%b %h required 011 ff",
                  vsync_out, hsync_out, de_out, bin_out);
      end
      px(0, 0, 1, 8'd50, 8'd50);
      tests++;
      if (bin_out !== 8'h00) begin
         fails++;
         $display("FAIL reset_nonskin: bin_out=%h required 00", bin_out);
      end
      px(0, 0, 0, 8'd0, 8'd0);
   endtask

   task automatic test_thresholds();
      logic [7:0] cbv [5];
      logic [7:0] crv [5];
      logic       dev [5];
      logic [7:0] exp_bin [5];
      cbv = '{8'd77, 8'd127, 8'd76, 8'd100, 8'd100};
      crv = '{8'd133, 8'd173, 8'd150, 8'd174, 8'd150};
      dev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_bin = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 5; i++) begin
         px(0, 0, dev[i], cbv[i], crv[i]);
         tests++;
         if (bin_out !== exp_bin[i] || de_out !== dev[i]) begin
            fails++;
            $display("FAIL threshold_%0d: bin_out=%h de_out=%b required %h %b",
                     i, bin_out, de_out, exp_bin[i], dev[i]);
         end
      end
      px(0, 0, 0, 8'd0, 8'd0);
      // Three skin pixels so far since reset: below MIN_PIX.
      frame_edge();
      tests++;
      if (box_update !== 1'b1 || skin_cnt !== 20'd3 || box_valid !== 1'b0 || box_x_max !== 12'd0) begin
         fails++;
         $display("FAIL threshold_publish: upd=%b cnt=%0d valid=%b xmax=%0d required 1 3 0 0",
                  box_update, skin_cnt, box_valid, box_x_max);
      end
      px(0, 0, 0, 8'd0, 8'd0);
      tests++;
      if (box_update !== 1'b0) begin
         fails++;
         $display("FAIL update_width: box_update=%b required 0", box_update);
      end
   endtask

   task automatic test_box_frame();
      send_frame(64, 48, 10, 29, 5, 24);
      frame_edge();
      tests++;
      if (box_update !== 1'b1 || box_valid !== 1'b1 || skin_cnt !== 20'd400) begin
         fails++;
         $display("FAIL box_frame_status: upd=%b valid=%b cnt=%0d required 1 1 400",
                  box_update, box_valid, skin_cnt);
      end
      tests++;
      if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {12'd10, 12'd29, 12'd5, 12'd24}) begin
         fails++;
         $display("FAIL box_frame_coords: box=(%0d,%0d,%0d,%0d) required (10,29,5,24)",
                  box_x_min, box_x_max, box_y_min, box_y_max);
      end
      repeat (5) px(0, 0, 0, 8'd0, 8'd0);
      tests++;
      if (box_x_max !== 12'd29 || skin_cnt !== 20'd400 || box_update !== 1'b0) begin
         fails++;
         $display("FAIL box_hold: xmax=%0d cnt=%0d upd=%b required 29 400 0",
                  box_x_max, skin_cnt, box_update);
      end
   endtask

   task automatic test_empty_frame();
      send_frame(16, 4, 1, 0, 1, 0);
      frame_edge();
      tests++;
      if (box_update !== 1'b1 || box_valid !== 1'b0 || skin_cnt !== 20'd0 || box_x_max !== 12'd0) begin
         fails++;
         $display("FAIL empty_frame: upd=%b valid=%b cnt=%0d xmax=%0d required 1 0 0 0",
                  box_update, box_valid, skin_cnt, box_x_max);
      end
      px(0, 0, 0, 8'd0, 8'd0);
   endtask

   task automatic test_below_threshold();
      send_frame(64, 48, 3, 12, 2, 11);
      frame_edge();
      tests++;
      if (box_update !== 1'b1 || box_valid !== 1'b0 || skin_cnt !== 20'd100) begin
         fails++;
         $display("FAIL below_status: upd=%b valid=%b cnt=%0d required 1 0 100",
                  box_update, box_valid, skin_cnt);
      end
      tests++;
      if ({box_x_min, box_x_max, box_y_min, box_y_max} !== 48'd0) begin
         fails++;
         $display("FAIL below_coords: box=(%0d,%0d,%0d,%0d) required all 0",
                  box_x_min, box_x_max, box_y_min, box_y_max);
      end
      px(0, 0, 0, 8'd0, 8'd0);
   endtask

   task automatic test_back_to_back();
      repeat (5) px(0, 0, 1, 8'd100, 8'd150);
      repeat (2) px(0, 0, 0, 8'd0, 8'd0);
      px(1, 0, 0, 8'd0, 8'd0);
      px(0, 0, 0, 8'd0, 8'd0);
      tests++;
      if (box_update !== 1'b1 || skin_cnt !== 20'd5) begin
         fails++;
         $display("FAIL b2b_first: upd=%b cnt=%0d required 1 5", box_update, skin_cnt);
      end
      px(1, 0, 0, 8'd0, 8'd0);
      tests++;
      if (box_update !== 1'b0) begin
         fails++;
         $display("FAIL b2b_gap: upd=%b required 0", box_update);
      end
      px(0, 0, 0, 8'd0, 8'd0);
      tests++;
      if (box_update !== 1'b1 || skin_cnt !== 20'd0) begin
         fails++;
         $display("FAIL b2b_second: upd=%b cnt=%0d required 1 0", box_update, skin_cnt);
      end
      px(0, 0, 0, 8'd0, 8'd0);
   endtask

   task automatic test_boundary_pixel();
      send_frame(32, 20, 0, 14, 0, 19);
      px(1, 0, 1, 8'd100, 8'd150);
      tests++;
      if (bin_out !== 8'hFF || vsync_out !== 1'b1) begin
         fails++;
         $display("FAIL boundary_bin: bin_out=%h vsync_out=%b required ff 1", bin_out, vsync_out);
      end
      px(1, 0, 0, 8'd0, 8'd0);
      tests++;
      if (box_update !== 1'b1 || skin_cnt !== 20'd300 || box_valid !== 1'b1 || box_x_max !== 12'd14) begin
         fails++;
         $display("FAIL boundary_publish: upd=%b cnt=%0d valid=%b xmax=%0d required 1 300 1 14",
                  box_update, skin_cnt, box_valid, box_x_max);
      end
      px(0, 0, 0, 8'd0, 8'd0);
      send_frame(8, 2, 1, 0, 1, 0);
      frame_edge();
      tests++;
      if (box_update !== 1'b1 || skin_cnt !== 20'd0 || box_valid !== 1'b0) begin
         fails++;
         $display("FAIL boundary_next: upd=%b cnt=%0d valid=%b required 1 0 0",
                  box_update, skin_cnt, box_valid);
      end
      px(0, 0, 0, 8'd0, 8'd0);
   endtask

   task automatic test_reset_midframe();
      send_frame(20, 2, 0, 19, 0, 1);
      px(0, 0, 1, 8'd100, 8'd150);
      px(0, 0, 1, 8'd100, 8'd150);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({de_out, bin_out, skin_cnt, box_valid, box_update} !== '0) begin
         fails++;
         $display("FAIL midframe_reset: de=%b bin=%h cnt=%0d valid=%b upd=%b required all 0",
                  de_out, bin_out, skin_cnt, box_valid, box_update);
      end
      repeat (2) px(0, 0, 1, 8'd100, 8'd150);
      de_in = 1'b0;
      rst_n = 1'b1;
      repeat (3) px(0, 0, 1, 8'd100, 8'd150);
      repeat (2) px(0, 0, 0, 8'd0, 8'd0);
      frame_edge();
      tests++;
      if (box_update !== 1'b1 || skin_cnt !== 20'd3 || box_valid !== 1'b0) begin
         fails++;
         $display("FAIL midframe_publish: upd=%b cnt=%0d valid=%b required 1 3 0",
                  box_update, skin_cnt, box_valid);
      end
      px(0, 0, 0, 8'd0, 8'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      vsync_in = 0; hsync_in = 0; de_in = 0; y = 0; cb = 0; cr = 0;
      #1 rst_n = 1'b0;
      test_reset();
      test_thresholds();
      test_box_frame();
      test_empty_frame();
      test_below_threshold();
      test_back_to_back();
      test_boundary_pixel();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ycbcr_skin_box.md
Name: ycbcr_skin_box

Overview:
- Sits directly downstream of the RGB565-to-YCbCr converter and consumes its y/cb/cr stream with the matching vsync/hsync/de.
- Per pixel, classifies skin colour with Cb/Cr window thresholds and outputs a registered binary mask stream with delay-matched syncs.
- Per frame, accumulates the skin bounding box and skin-pixel count, then publishes them at each frame boundary for the overlay/tracking logic.

Parameters:
- CB_MIN, 77, inclusive lower Cb bound for skin
- CB_MAX, 127, inclusive upper Cb bound for skin
- CR_MIN, 133, inclusive lower Cr bound for skin
- CR_MAX, 173, inclusive upper Cr bound for skin
- COORD_W, 12, width of the x/y pixel coordinate counters
- CNT_W, 20, width of the skin-pixel counter
- MIN_PIX, 256, minimum skin count for a frame's box to be declared valid

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- vsync_in  in  1  frame sync, active-high; its rising edge is the frame boundary
- hsync_in  in  1  line sync (pass-through only)
- de_in  in  1  active-pixel enable
- y  in  8  luma (pass-through only)
- cb  in  8  Cb
- cr  in  8  Cr
- vsync_out  out  1  vsync_in delayed 1 cycle
- hsync_out  out  1  hsync_in delayed 1 cycle
- de_out  out  1  de_in delayed 1 cycle
- bin_out  out  8  8'hFF if the pixel is skin and de_in=1, else 8'h00; 1-cycle latency
- box_x_min  out  COORD_W  leftmost skin column of the last frame
- box_x_max  out  COORD_W  rightmost skin column of the last frame
- box_y_min  out  COORD_W  top skin line of the last frame
- box_y_max  out  COORD_W  bottom skin line of the last frame
- skin_cnt  out  CNT_W  skin pixel count of the last frame
- box_valid  out  1  last frame's skin_cnt >= MIN_PIX
- box_update  out  1  one-cycle pulse when the box_*/skin_cnt/box_valid outputs change

Behaviour:
- Reset: every output, delay register, counter and accumulator goes to 0. Exceptions: x_min_acc and y_min_acc reset to all-ones.
- Skin test (combinational):
  - skin = de_in AND CB_MIN <= cb <= CB_MAX AND CR_MIN <= cr <= CR_MAX.
  - Bounds are inclusive; comparisons are unsigned 8-bit.
- Pixel path:
  - bin_out, vsync_out, hsync_out and de_out are registered together, giving exactly 1 cycle latency.
  - bin_out is never nonzero while de_out=0.
- Edge detection: vsync_d and de_d (previous-cycle samples) give vs_rise = vsync_in & ~vsync_d and de_fall = ~de_in & de_d.
- x counter:
  - Increments on each cycle with de_in=1.
  - Cleared on any cycle with de_in=0, so column 0 is the first active pixel of a line.
  - Saturates at 2^COORD_W-1; no wrap.
- y counter:
  - Increments on de_fall and saturates at 2^COORD_W-1.
  - Cleared on vs_rise, so line 0 is the first active line after vsync.
  - If vs_rise and de_fall coincide, the clear wins.
- Accumulators, updated on a skin pixel when vs_rise=0:
  - x_min_acc = min(x_min_acc, x) and x_max_acc = max(x_max_acc, x); y_min_acc and y_max_acc likewise with y.
  - cnt_acc increments and saturates at 2^CNT_W-1.
- Frame publish FSM, two states:
  - ACCUM (reset state): accumulate. On vs_rise, go to PUBLISH.
  - PUBLISH (1 cycle):
    - If cnt_acc >= MIN_PIX, then box_* <= accumulators and box_valid <= 1.
    - Otherwise box_* <= 0 and box_valid <= 0.
    - In both cases skin_cnt <= cnt_acc and box_update pulses to 1 on the following cycle.
    - The snapshot is taken on the vs_rise cycle; accumulators are reinitialised (min=all-ones, max=0, cnt=0) on that same cycle.
    - Then return to ACCUM.
- A skin pixel arriving on the vs_rise cycle is still binarised but is excluded from both frames' statistics.
- A back-to-back vs_rise arriving while in PUBLISH is treated as a new frame boundary (publishes a zero-count frame next).
- Published values hold until the next publish.
- Reset mid-frame: all state is discarded. The first publish after reset reflects only pixels seen after reset.
- Widths: x/y comparisons use COORD_W-bit unsigned; no arithmetic overflow is possible beyond the defined saturations.

Test Plan:
- Reset check: hold rst_n=0 mid-stream -> all outputs 0; after release, bin_out follows de_in/cb/cr with 1 cycle latency and syncs match.
- Threshold edges: de=1 with (cb,cr) = (77,133), (127,173), (76,150), (100,174) -> bin_out = FF, FF, 00, 00 one cycle later; de=0 with (100,150) -> 00.
- Box frame: 64x48 frame with skin block at columns 10..29, lines 5..24 (400 px), then vsync rise -> box_update pulse; box = (10,29,5,24); skin_cnt=400; box_valid=1.
- Below threshold: same frame with a 10x10 block (100 px < 256) -> box_valid=0, box_* all 0, skin_cnt=100, box_update pulses.
- Empty/consecutive frames: a frame with no skin after a valid frame -> box_valid=0, skin_cnt=0. Two vsync rises 2 cycles apart -> two box_update pulses, second with count 0.
- Boundary pixel: skin pixel asserted on the exact vs_rise cycle -> bin_out=FF, but the pixel is absent from both the published and the next frame's count.
